// File: rtl/countbits_rr_scheduler.sv
// Round-robin shares one CHUNK-bit popcount slice among NREQ requesters; answers with id/ones/zeros.
// Latency: accept at edge T -> rsp_valid after edge T+NCHUNK; one request per NCHUNK+2 cycles max.
// Backpressure: rsp_ready low holds the response stable; req_ready stays low outside IDLE.
module countbits_rr_scheduler #(
    parameter  int NREQ   = 4,
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(WIDTH + 1),
    localparam int IW     = $clog2(NREQ),
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [CW-1:0]         rsp_ones,
    output logic [CW-1:0]         rsp_zeros,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gid_q, gid_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     ones_q, ones_d;
    logic [CW-1:0]     zeros_q, zeros_d;
    logic [IW-1:0]     id_q, id_d;

    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx;
    logic [CW-1:0]     acc_sum;

    function automatic logic [CW-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int b = 0; b < CHUNK; b++) begin
            c = c + CW'(v[b]);
        end
        return c;
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!gnt_vld && req_valid[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    assign acc_sum = acc_q + popcnt(word_q[CHUNK-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ones_q  <= '0;
            zeros_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ones_d  = ones_q;
        zeros_d = zeros_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    word_d  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
                    gid_d   = gnt_idx;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // The word shifts down so the slice always sees the low chunk.
                if (cnt_q == KW'(NCHUNK - 1)) begin
                    ones_d  = acc_sum;
                    zeros_d = CW'(WIDTH) - acc_sum;
                    id_d    = gid_q;
                    state_d = S_RESP;
                end else begin
                    acc_d  = acc_sum;
                    cnt_d  = cnt_q + 1'b1;
                    word_d = word_q >> CHUNK;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        rsp_id    = id_q;
        rsp_ones  = ones_q;
        rsp_zeros = zeros_q;
    end

endmodule

// File: tb/tb_countbits_rr_scheduler.sv
// Bench for countbits_rr_scheduler: table vectors, hand-written corner sequences,
// and randomized requests against a priority-list reference model.
module tb_countbits_rr_scheduler;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int IW     = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [CW-1:0]         rsp_ones;
    logic [CW-1:0]         rsp_zeros;
    logic                  busy;

    always #5 clk = ~clk;

    countbits_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ones  (rsp_ones),
        .rsp_zeros (rsp_zeros),
        .busy      (busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int prio[$];

    typedef struct {
        logic [NREQ-1:0]  vmask;
        logic [WIDTH-1:0] word;
        int               exp_id;
        int               exp_ones;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference arbiter: an ordered priority list; the granted id moves to the back.
    task automatic model_reset();
        prio.delete();
        for (int i = 0; i < NREQ; i++) prio.push_back(i);
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] mask);
        foreach (prio[k]) if (mask[prio[k]]) return prio[k];
        return -1;
    endfunction

    task automatic model_grant(input int g);
        for (int n = 0; n < NREQ && prio[$] != g; n++) prio.push_back(prio.pop_front());
    endtask

    function automatic logic [NREQ-1:0] onehot(input int id);
        logic [NREQ-1:0] r;
        r = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    function automatic int lane_ones(input int id);
        logic [WIDTH-1:0] w;
        w = req_data[id*WIDTH +: WIDTH];
        return $countones(w);
    endfunction

    task automatic randomize_lanes();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic do_txn(input logic [NREQ-1:0] vmask, input int exp_id, input int exp_ones,
                          input string tag);
        int edges;
        req_valid = vmask;
        rsp_ready = 1'b1;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'(onehot(exp_id)));
        @(negedge clk);
        req_valid = '0;
        randomize_lanes();
        #1;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        edges = 0;
        while (rsp_valid !== 1'b1 && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, " latency"}, edges, NCHUNK);
        chk({tag, " rsp_id"}, 32'(rsp_id), exp_id);
        chk({tag, " rsp_ones"}, 32'(rsp_ones), exp_ones);
        chk({tag, " rsp_zeros"}, 32'(rsp_zeros), WIDTH - exp_ones);
        @(negedge clk);
        chk({tag, " rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
        model_grant(exp_id);
    endtask

    initial begin
        int exp_seq[5];
        int seen, last_t, cyc, g, edges;
        logic [NREQ-1:0] mask;

        vecs[0] = '{4'b0100, 32'hF0F0_00FF, 2, 16};
        vecs[1] = '{4'b0001, 32'h0000_0000, 0, 0};
        vecs[2] = '{4'b0010, 32'hFFFF_FFFF, 1, 32};
        vecs[3] = '{4'b1000, 32'h8000_0001, 3, 2};
        vecs[4] = '{4'b1010, 32'h1234_5678, 1, 13};
        vecs[5] = '{4'b0011, 32'hA5A5_A5A5, 0, 16};
        vecs[6] = '{4'b1111, 32'h0000_FFFF, 1, 16};
        exp_seq = '{0, 1, 2, 3, 0};

        do_reset();
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset rsp_ones", 32'(rsp_ones), 0);
        chk("reset rsp_zeros", 32'(rsp_zeros), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset req_ready", 32'(req_ready), 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            for (int l = 0; l < NREQ; l++) req_data[l*WIDTH +: WIDTH] = ~vecs[i].word;
            req_data[vecs[i].exp_id*WIDTH +: WIDTH] = vecs[i].word;
            do_txn(vecs[i].vmask, vecs[i].exp_id, vecs[i].exp_ones, $sformatf("vec%0d", i));
        end

        // Fairness under continuous requests from everyone.
        do_reset();
        randomize_lanes();
        req_valid = '1;
        rsp_ready = 1'b1;
        seen = 0; last_t = 0; cyc = 0;
        while (seen < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                chk($sformatf("rr id%0d", seen), 32'(rsp_id), exp_seq[seen]);
                chk($sformatf("rr ones%0d", seen), 32'(rsp_ones), lane_ones(exp_seq[seen]));
                if (seen > 0) chk($sformatf("rr gap%0d", seen), cyc - last_t, NCHUNK + 2);
                model_grant(exp_seq[seen]);
                last_t = cyc;
                seen++;
                if (seen == 5) req_valid = '0;
            end
        end
        chk("rr count", seen, 5);
        @(negedge clk);
        chk("rr idle", 32'(busy), 0);

        // Backpressure: response held for 10 cycles while others wait.
        randomize_lanes();
        req_data[2*WIDTH +: WIDTH] = 32'h0F0F_0F0F;
        g = model_pick(4'b0100);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '1;
        edges = 0;
        while (rsp_valid !== 1'b1 && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        chk("bp latency", edges, NCHUNK);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp rsp_valid", 32'(rsp_valid), 1);
            chk("bp rsp_id", 32'(rsp_id), g);
            chk("bp rsp_ones", 32'(rsp_ones), 16);
            chk("bp req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        model_grant(g);
        @(negedge clk);
        #1;
        chk("bp rsp_valid_drop", 32'(rsp_valid), 0);
        chk("bp next grant", 32'(req_ready), 32'(onehot(model_pick('1))));
        req_valid = '0;
        @(negedge clk);
        chk("bp dropped request", 32'(busy), 0);

        // Reset in the middle of counting discards the operation.
        randomize_lanes();
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        chk("mid busy before reset", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid busy", 32'(busy), 0);
        chk("mid rsp_valid", 32'(rsp_valid), 0);
        chk("mid rsp_id", 32'(rsp_id), 0);
        chk("mid rsp_ones", 32'(rsp_ones), 0);
        chk("mid rsp_zeros", 32'(rsp_zeros), 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid no response", 32'(rsp_valid), 0);
        end
        rst_n = 1'b1;
        model_reset();
        do_txn('1, model_pick('1), lane_ones(model_pick('1)), "post reset");

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            mask = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            randomize_lanes();
            if (mask == '0) begin
                req_valid = '0;
                #1;
                chk("rand idle req_ready", 32'(req_ready), 0);
                @(negedge clk);
                chk("rand idle busy", 32'(busy), 0);
            end else begin
                g = model_pick(mask);
                do_txn(mask, g, lane_ones(g), $sformatf("rand%0d", t));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
